// File: rtl/q2fsm_pkg.sv
// Shared types and constants for the q2fsm pattern transmitter.
package q2fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAP   = 2'd3
  } tx_state_t;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_GAP_CYCLES = 2;
  // Two zeros return the downstream detector to idle from any state
  localparam int unsigned MIN_GAP        = 2;

endpackage

// File: rtl/q2fsm_tx_shreg.sv
// Loadable left-shift register; the MSB is the serial bit and parity is captured at load.
module q2fsm_tx_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb,
  output logic             parity
);

  logic [WIDTH-1:0] q;
  logic             par_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q     <= '0;
      par_q <= 1'b0;
    end else if (load) begin
      q     <= d;
      par_q <= ^d;
    end else if (shift) begin
      q     <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb    = q[WIDTH-1];
  assign parity = par_q;

endmodule

// File: rtl/q2fsm_pattern_tx.sv
// Serial pattern transmitter feeding the 2012-q2 sequence detector.
// Optional even-parity bit after the data word: define Q2FSM_TX_PARITY_EN.
module q2fsm_pattern_tx
  import q2fsm_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             w,
  output logic             busy,
  output logic             done
);

  localparam int unsigned GAP_EFF = (GAP_CYCLES < MIN_GAP) ? MIN_GAP : GAP_CYCLES;
  localparam int unsigned BIT_W   = $clog2(WIDTH);
  localparam int unsigned GAP_W   = $clog2(GAP_EFF + 1);

  tx_state_t        state, state_d;
  logic [BIT_W-1:0] bit_cnt, bit_d;
  logic [GAP_W-1:0] gap_cnt, gap_d;
  logic             ld, sh, done_d, par_bit;
  logic [WIDTH-1:0] ld_data;

  // The shift register MSB is the w flop; it is all-zero outside SHIFT/PAR.
  q2fsm_tx_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (ld),
    .shift  (sh),
    .d      (ld_data),
    .msb    (w),
    .parity (par_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_d;
      gap_cnt  <= gap_d;
      in_ready <= (state_d == IDLE);
      busy     <= (state_d != IDLE);
      done     <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    bit_d   = bit_cnt;
    gap_d   = gap_cnt;
    ld      = 1'b0;
    sh      = 1'b0;
    ld_data = in_data;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = SHIFT;
          bit_d   = BIT_W'(WIDTH - 1);
          ld      = 1'b1;
        end
      end
      SHIFT: begin
        // Reload slot: parity bit placed at the MSB, zeros behind it
        ld_data = {par_bit, {(WIDTH-1){1'b0}}};
        if (bit_cnt == '0) begin
`ifdef Q2FSM_TX_PARITY_EN
          state_d = PAR;
          ld      = 1'b1;
`else
          state_d = GAP;
          gap_d   = GAP_W'(GAP_EFF - 1);
          sh      = 1'b1;
`endif
        end else begin
          bit_d = bit_cnt - BIT_W'(1);
          sh    = 1'b1;
        end
      end
`ifdef Q2FSM_TX_PARITY_EN
      PAR: begin
        state_d = GAP;
        gap_d   = GAP_W'(GAP_EFF - 1);
        sh      = 1'b1;
      end
`endif
      GAP: begin
        if (gap_cnt == '0) begin
          state_d = IDLE;
        end else begin
          gap_d  = gap_cnt - GAP_W'(1);
          done_d = (gap_cnt == GAP_W'(1));
        end
      end
      default: begin
        // Unreachable encodings: flush the serial path and return to idle
        state_d = IDLE;
        bit_d   = '0;
        gap_d   = '0;
        ld      = 1'b1;
        ld_data = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_q2fsm_pattern_tx.sv
// Scoreboard bench for q2fsm_pattern_tx with a behavioural frame model and detector loopback.
module tb_q2fsm_pattern_tx;

  localparam int unsigned W = 8;
  localparam int unsigned G = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, w, busy, done;

  typedef struct packed {
    logic w;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   det = 0;

  q2fsm_pattern_tx #(.WIDTH(W), .GAP_CYCLES(G)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .w       (w),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference frame: data MSB first, optional even parity, then G zero bits with done on the last.
  function automatic void push_frame(input logic [W-1:0] d);
    exp_t e;
    for (int i = W - 1; i >= 0; i--) begin
      e.w = d[i]; e.done = 1'b0; exp_q.push_back(e);
    end
`ifdef Q2FSM_TX_PARITY_EN
    e.w = ^d; e.done = 1'b0; exp_q.push_back(e);
`endif
    for (int g = 0; g < int'(G); g++) begin
      e.w = 1'b0; e.done = (g == int'(G) - 1); exp_q.push_back(e);
    end
  endfunction

  // 2012-q2 detector: states A..F = 0..5; z=1 in E and F.
  function automatic int det_next(input int s, input logic b);
    case (s)
      0: return b ? 1 : 0;
      1: return b ? 2 : 3;
      2: return b ? 4 : 3;
      3: return b ? 5 : 0;
      4: return b ? 4 : 3;
      default: return b ? 2 : 3;
    endcase
  endfunction

  // One driven cycle, called at a negedge; records an accept before the edge happens.
  task automatic drive(input logic v, input logic [W-1:0] d);
    in_valid = v;
    in_data  = d;
    if (v && in_ready) push_frame(d);
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] d);
    int budget = 100;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      push_frame(d);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  // Monitor: compare every cycle shortly after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        chk("rst_w", 32'(w), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        det = 0;
      end else if (busy) begin
        chk("ready_while_busy", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_busy", 32'(busy), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("w_bit", 32'(w), 32'(e.w));
          chk("done_flag", 32'(done), 32'(e.done));
          det = det_next(det, w);
          if (e.done) chk("detector_idle_at_boundary", 32'(det), 32'd0);
        end
      end else begin
        chk("idle_w", 32'(w), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("frame_len", 32'(exp_q.size()), 32'd0);
        det = det_next(det, w);
      end
    end
  end

  initial begin
    int budget;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_reset", 32'(in_ready), 32'd1);
    @(negedge clk);

    send(8'hB6);
    repeat (3) @(negedge clk);
    send(8'hFF);
    send(8'h00);
    send(8'hE0);
    send(8'h60);
    send(8'h07);

    // Abort mid-frame with an asynchronous reset
    send(8'hA5);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_w", 32'(w), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(8'h81);

    repeat (300) drive(1'($urandom_range(0, 1)), W'($urandom));
    in_valid = 1'b0;

    budget = 100;
    while ((exp_q.size() != 0 || busy) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
